// File: rtl/pool_out_fifo_if.sv
// Valid/ready stream carrying pooled pixels and their frame/line tags
// from the output FIFO to the writeback/DMA stage.
interface pool_out_fifo_if #(
  parameter int DW = 16
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          sof;
  logic          sol;
  logic          last;

  modport master (output valid, data, sof, sol, last, input ready);
  modport slave  (input valid, data, sof, sol, last, output ready);
endinterface

// File: rtl/pool_out_fifo.sv
// Output buffer of the max-pooling block: tags pooled beats with SOF/SOL/LAST,
// delays each beat by one to attach LAST, and queues them in a FWFT FIFO.
module pool_out_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int CW    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_frame_start,
  input  logic                 in_line_start,
  input  logic                 in_frame_end,
  pool_out_fifo_if.master      out_if,
  output logic [AW:0]          fifo_level,
  output logic                 overflow,
  input  logic                 clr_overflow,
  output logic [CW-1:0]        frame_beats
);

  localparam int            EW       = DW + 3;
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + {{(CW-1){1'b0}}, 1'b1};
    end
  endfunction

  logic [EW-1:0] mem_q [DEPTH];

  logic          hold_valid_q, hold_valid_d;
  logic [DW-1:0] hold_data_q,  hold_data_d;
  logic          hold_sof_q,   hold_sof_d;
  logic          hold_sol_q,   hold_sol_d;
  logic          sof_pend_q,   sof_pend_d;
  logic          sol_pend_q,   sol_pend_d;
  logic          end_pend_q,   end_pend_d;
  logic [AW-1:0] wr_ptr_q,     wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,     rd_ptr_d;
  logic [AW:0]   level_q,      level_d;
  logic          overflow_q,   overflow_d;
  logic [CW-1:0] cnt_q,        cnt_d;
  logic [CW-1:0] frame_beats_q, frame_beats_d;

  logic          wr_req, wr_last, wr_ok, wr_drop, in_drop, close_empty;
  logic          beat_sof, beat_sol, pop, not_empty;
  logic [EW-1:0] wr_entry, head;

  // Hold stage and tag capture: decides which beat, if any, is offered to the FIFO
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_sof_d   = hold_sof_q;
    hold_sol_d   = hold_sol_q;
    sof_pend_d   = sof_pend_q | in_frame_start;
    sol_pend_d   = sol_pend_q | in_frame_start | in_line_start;
    end_pend_d   = end_pend_q;
    beat_sof     = sof_pend_q | in_frame_start;
    beat_sol     = sol_pend_q | in_line_start | in_frame_start;
    wr_req       = 1'b0;
    wr_last      = 1'b0;
    in_drop      = 1'b0;
    close_empty  = 1'b0;
    if (end_pend_q) begin
      // Frame end arrived with the final beat: flush it now; a colliding beat is lost.
      wr_req       = 1'b1;
      wr_last      = 1'b1;
      hold_valid_d = 1'b0;
      end_pend_d   = 1'b0;
      if (in_valid) begin
        in_drop = 1'b1;
      end else begin
        in_drop = 1'b0;
      end
    end else if (in_valid) begin
      wr_req       = hold_valid_q;
      hold_valid_d = 1'b1;
      hold_data_d  = in_data;
      hold_sof_d   = beat_sof;
      hold_sol_d   = beat_sol;
      sof_pend_d   = 1'b0;
      sol_pend_d   = 1'b0;
      end_pend_d   = in_frame_end;
    end else if (in_frame_end) begin
      if (hold_valid_q) begin
        wr_req       = 1'b1;
        wr_last      = 1'b1;
        hold_valid_d = 1'b0;
      end else begin
        close_empty  = 1'b1;
      end
    end else begin
      wr_req = 1'b0;
    end
    wr_entry = {hold_sof_q, hold_sol_q, wr_last, hold_data_q};
  end

  // FIFO pointers, occupancy, drop detection and beat accounting
  always_comb begin
    not_empty = (level_q != {(AW+1){1'b0}});
    pop       = not_empty & out_if.ready;
    wr_ok     = wr_req & ((level_q != LVL_FULL) | pop);
    wr_drop   = wr_req & ~wr_ok;
    wr_ptr_d  = wr_ok ? (wr_ptr_q + {{(AW-1){1'b0}}, 1'b1}) : wr_ptr_q;
    rd_ptr_d  = pop   ? (rd_ptr_q + {{(AW-1){1'b0}}, 1'b1}) : rd_ptr_q;
    case ({wr_ok, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    cnt_d         = cnt_q;
    frame_beats_d = frame_beats_q;
    // A LAST beat closes the frame even when it is dropped.
    if (wr_req && wr_last) begin
      frame_beats_d = wr_ok ? sat_inc(cnt_q) : cnt_q;
      cnt_d         = {CW{1'b0}};
    end else if (close_empty) begin
      frame_beats_d = cnt_q;
      cnt_d         = {CW{1'b0}};
    end else if (wr_ok) begin
      cnt_d         = sat_inc(cnt_q);
    end else begin
      cnt_d         = cnt_q;
    end
    if (wr_drop || in_drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control state; async reset discards held and stored beats at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q  <= 1'b0;
      hold_data_q   <= {DW{1'b0}};
      hold_sof_q    <= 1'b0;
      hold_sol_q    <= 1'b0;
      sof_pend_q    <= 1'b0;
      sol_pend_q    <= 1'b0;
      end_pend_q    <= 1'b0;
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      level_q       <= {(AW+1){1'b0}};
      overflow_q    <= 1'b0;
      cnt_q         <= {CW{1'b0}};
      frame_beats_q <= {CW{1'b0}};
    end else begin
      hold_valid_q  <= hold_valid_d;
      hold_data_q   <= hold_data_d;
      hold_sof_q    <= hold_sof_d;
      hold_sol_q    <= hold_sol_d;
      sof_pend_q    <= sof_pend_d;
      sol_pend_q    <= sol_pend_d;
      end_pend_q    <= end_pend_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      overflow_q    <= overflow_d;
      cnt_q         <= cnt_d;
      frame_beats_q <= frame_beats_d;
    end
  end

  // Storage array; contents are don't-care until covered by level
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  // Head presentation, forced to zero while empty
  always_comb begin
    head         = not_empty ? mem_q[rd_ptr_q] : {EW{1'b0}};
    out_if.valid = not_empty;
    out_if.data  = head[DW-1:0];
    out_if.last  = head[DW];
    out_if.sol   = head[DW+1];
    out_if.sof   = head[DW+2];
    fifo_level   = level_q;
    overflow     = overflow_q;
    frame_beats  = frame_beats_q;
  end

endmodule

// File: tb/tb_pool_out_fifo.sv
// Directed bench for pool_out_fifo: expected beats are queued by hand per
// scenario and compared against the FIFO head whenever it is accepted.
module tb_pool_out_fifo;
  localparam int DW = 16;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_frame_start = 1'b0;
  logic          in_line_start = 1'b0;
  logic          in_frame_end = 1'b0;
  logic          clr_overflow = 1'b0;
  logic          rdy = 1'b0;
  logic [AW:0]   fifo_level;
  logic          overflow;
  logic [CW-1:0] frame_beats;

  int total = 0;
  int bad = 0;
  logic [DW+2:0] exp_q[$];
  logic [DW+2:0] head;

  pool_out_fifo_if #(.DW(DW)) out_if ();

  pool_out_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_frame_start(in_frame_start), .in_line_start(in_line_start),
    .in_frame_end(in_frame_end), .out_if(out_if), .fifo_level(fifo_level),
    .overflow(overflow), .clr_overflow(clr_overflow), .frame_beats(frame_beats)
  );

  always #5 clk = ~clk;
  assign out_if.ready = rdy;
  assign head = {out_if.sof, out_if.sol, out_if.last, out_if.data};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check the head if it is about to be accepted, then advance.
  task automatic step();
    if (out_if.valid && rdy) begin
      if (exp_q.size() != 0) chk("beat", 32'(head), 32'(exp_q.pop_front()));
      else chk("extra_beat", 32'(out_if.valid), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic fs,
                       input logic ls, input logic fe);
    in_valid = v; in_data = d; in_frame_start = fs; in_line_start = ls; in_frame_end = fe;
    step();
    in_valid = 1'b0; in_data = '0; in_frame_start = 1'b0; in_line_start = 1'b0; in_frame_end = 1'b0;
  endtask

  task automatic drain(input string tag);
    rdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (exp_q.size() == 0 && !out_if.valid) break;
      step();
    end
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
  endtask

  function automatic logic [DW+2:0] ent(input logic s, input logic l, input logic t,
                                        input logic [DW-1:0] d);
    return {s, l, t, d};
  endfunction

  initial begin
    #12;
    chk("rst_valid", 32'(out_if.valid), 32'd0);
    chk("rst_data", 32'(out_if.data), 32'd0);
    chk("rst_flags", 32'({out_if.sof, out_if.sol, out_if.last}), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_fb", 32'(frame_beats), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: four beats then frame end, consumer always ready
    rdy = 1'b1;
    exp_q.push_back(ent(1'b1, 1'b1, 1'b0, 16'h0010));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 16'h0011));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 16'h0012));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b1, 16'h0013));
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 16'h0010 + 16'(i), 1'b0, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    drain("t1");
    chk("t1_fb", 32'(frame_beats), 32'd4);
    chk("t1_ovf", 32'(overflow), 32'd0);

    // 2: two lines of three beats
    exp_q.push_back(ent(1'b1, 1'b1, 1'b0, 16'h0020));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 16'h0021));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 16'h0022));
    exp_q.push_back(ent(1'b0, 1'b1, 1'b0, 16'h0023));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 16'h0024));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b1, 16'h0025));
    drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 16'h0020 + 16'(i), 1'b0, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    for (int i = 3; i < 6; i++) drive(1'b1, 16'h0020 + 16'(i), 1'b0, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    drain("t2");
    chk("t2_fb", 32'(frame_beats), 32'd6);

    // 3: 40 beats against a stalled consumer; only the first 32 survive
    rdy = 1'b0;
    exp_q.push_back(ent(1'b1, 1'b1, 1'b0, 16'h0100));
    for (int i = 1; i < 32; i++) exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 16'h0100 + 16'(i)));
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) drive(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("t3_level", 32'(fifo_level), 32'd32);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_fb", 32'(frame_beats), 32'd32);
    drain("t3");
    chk("t3_ovf_sticky", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    chk("t3_ovf_clr", 32'(overflow), 32'd0);

    // 4: frame end coincides with the only beat
    rdy = 1'b1;
    exp_q.push_back(ent(1'b1, 1'b1, 1'b1, 16'h00AB));
    drive(1'b1, 16'h00AB, 1'b1, 1'b0, 1'b1);
    chk("t4_lat1", 32'(out_if.valid), 32'd0);
    step();
    chk("t4_lat2", 32'(out_if.valid), 32'd1);
    drain("t4");
    chk("t4_fb", 32'(frame_beats), 32'd1);
    chk("t4_ovf", 32'(overflow), 32'd0);

    // 5: full FIFO with push and pop in the same cycle, across pointer wrap
    rdy = 1'b0;
    exp_q.push_back(ent(1'b1, 1'b1, 1'b0, 16'h0200));
    for (int i = 1; i < 33; i++) exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 16'h0200 + 16'(i)));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b1, 16'h0221));
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 33; i++) drive(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0, 1'b0);
    chk("t5_full", 32'(fifo_level), 32'd32);
    rdy = 1'b1;
    drive(1'b1, 16'h0221, 1'b0, 1'b0, 1'b0);
    chk("t5_level_a", 32'(fifo_level), 32'd32);
    chk("t5_ovf_a", 32'(overflow), 32'd0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("t5_level_b", 32'(fifo_level), 32'd32);
    chk("t5_ovf_b", 32'(overflow), 32'd0);
    drain("t5");
    chk("t5_fb", 32'(frame_beats), 32'd34);

    // 6: asynchronous reset mid-frame, then a clean frame
    rdy = 1'b0;
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 16'h0300 + 16'(i), 1'b0, 1'b0, 1'b0);
    chk("t6_level", 32'(fifo_level), 32'd7);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_if.valid), 32'd0);
    chk("t6_rst_level", 32'(fifo_level), 32'd0);
    chk("t6_rst_fb", 32'(frame_beats), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rdy = 1'b1;
    exp_q.push_back(ent(1'b1, 1'b1, 1'b1, 16'h003A));
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 16'h003A, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    drain("t6");
    chk("t6_fb", 32'(frame_beats), 32'd1);
    chk("t6_ovf", 32'(overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
